// File: rtl/blake512_compress_ctrl.sv
// Iterative BLAKE-512 compression: one G call per clock over 16 rounds x 8 steps,
// followed by a finalization cycle that registers the new chaining value.
module blake512_compress_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [511:0]  h_in_i,
    input  logic [255:0]  s_in_i,
    input  logic [127:0]  t_in_i,
    input  logic [1023:0] m_in_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [511:0]  h_out_o
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     v_q [16];
    logic [63:0]     v_d [16];
    logic [511:0]    h_q, h_d;
    logic [255:0]    s_q, s_d;
    logic [1023:0]   m_q, m_d;
    logic [RW-1:0]   r_q, r_d;
    logic [2:0]      g_q, g_d;
    logic [511:0]    h_out_q, h_out_d;
    logic            done_q, done_d;

    // Each 64-bit row packs the 16 permutation entries, entry 0 in the top nibble.
    function automatic logic [3:0] sigma(input logic [3:0] row, input logic [3:0] idx);
        logic [63:0] bits;
        case (row)
            4'd1:    bits = 64'hEA489FD61C02B753;
            4'd2:    bits = 64'hB8C052FDAE367194;
            4'd3:    bits = 64'h7931DCBE265A40F8;
            4'd4:    bits = 64'h905724AFE1BC683D;
            4'd5:    bits = 64'h2C6A0B834D75FE19;
            4'd6:    bits = 64'hC51FED4A0763928B;
            4'd7:    bits = 64'hDB7EC13950F4862A;
            4'd8:    bits = 64'h6FE9B308C2D714A5;
            4'd9:    bits = 64'hA2847615FB9E3CD0;
            default: bits = 64'h0123456789ABCDEF;
        endcase
        return 4'(bits >> (6'd60 - {idx, 2'b00}));
    endfunction

    function automatic logic [63:0] cst(input logic [3:0] idx);
        case (idx)
            4'd0:    return 64'h243F6A8885A308D3;
            4'd1:    return 64'h13198A2E03707344;
            4'd2:    return 64'hA4093822299F31D0;
            4'd3:    return 64'h082EFA98EC4E6C89;
            4'd4:    return 64'h452821E638D01377;
            4'd5:    return 64'hBE5466CF34E90C6C;
            4'd6:    return 64'hC0AC29B7C97C50DD;
            4'd7:    return 64'h3F84D5B5B5470917;
            4'd8:    return 64'h9216D5D98979FB1B;
            4'd9:    return 64'hD1310BA698DFB5AC;
            4'd10:   return 64'h2FFD72DBD01ADFB7;
            4'd11:   return 64'hB8E1AFED6A267E96;
            4'd12:   return 64'hBA7C9045F12C7F99;
            4'd13:   return 64'h24A19947B3916CF7;
            4'd14:   return 64'h0801F2E2858EFC16;
            default: return 64'h636920D871574E69;
        endcase
    endfunction

    // G datapath for the current step
    logic [3:0]  ia, ib, ic, id, row, s0, s1;
    logic [63:0] a0, b0, c0, d0, a1, b1, c1, d1, a2, b2, c2, d2;
    logic [63:0] d1x, b1x, d2x, b2x;

    always_comb begin
        case (g_q)
            3'd4:    {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
            3'd7:    {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
            default: {ia, ib, ic, id} = {2'b00, g_q[1:0], 2'b01, g_q[1:0],
                                         2'b10, g_q[1:0], 2'b11, g_q[1:0]};
        endcase
        row = 4'(32'(r_q) % 32'd10);
        s0  = sigma(row, {g_q, 1'b0});
        s1  = sigma(row, {g_q, 1'b1});
        a0  = v_q[ia];
        b0  = v_q[ib];
        c0  = v_q[ic];
        d0  = v_q[id];

        a1  = a0 + b0 + (m_q[{s0, 6'b0} +: 64] ^ cst(s1));
        d1x = d0 ^ a1;
        d1  = {d1x[31:0], d1x[63:32]};
        c1  = c0 + d1;
        b1x = b0 ^ c1;
        b1  = {b1x[24:0], b1x[63:25]};

        a2  = a1 + b1 + (m_q[{s1, 6'b0} +: 64] ^ cst(s0));
        d2x = d1 ^ a2;
        d2  = {d2x[15:0], d2x[63:16]};
        c2  = c1 + d2;
        b2x = b1 ^ c2;
        b2  = {b2x[10:0], b2x[63:11]};
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        v_d     = v_q;
        h_d     = h_q;
        s_d     = s_q;
        m_d     = m_q;
        r_d     = r_q;
        g_d     = g_q;
        h_out_d = h_out_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    h_d = h_in_i;
                    s_d = s_in_i;
                    m_d = m_in_i;
                    for (int i = 0; i < 8; i++) v_d[i] = h_in_i[64*i +: 64];
                    for (int i = 0; i < 4; i++) v_d[8+i] = s_in_i[64*i +: 64] ^ cst(4'(i));
                    v_d[12] = t_in_i[63:0]   ^ cst(4'd4);
                    v_d[13] = t_in_i[63:0]   ^ cst(4'd5);
                    v_d[14] = t_in_i[127:64] ^ cst(4'd6);
                    v_d[15] = t_in_i[127:64] ^ cst(4'd7);
                    r_d     = '0;
                    g_d     = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                v_d[ia] = a2;
                v_d[ib] = b2;
                v_d[ic] = c2;
                v_d[id] = d2;
                if (g_q == 3'd7) begin
                    g_d = '0;
                    if (r_q == RW'(ROUNDS - 1)) state_d = S_FINAL;
                    else                        r_d     = r_q + 1'b1;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++)
                    h_out_d[64*i +: 64] = h_q[64*i +: 64] ^ s_q[64*(i%4) +: 64]
                                        ^ v_q[i] ^ v_q[i+8];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            // NOTE: the v file is small and register-based, so it is reset with the rest of the state.
            for (int i = 0; i < 16; i++) v_q[i] <= '0;
            h_q     <= '0;
            s_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            h_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q <= state_d;
            v_q     <= v_d;
            h_q     <= h_d;
            s_q     <= s_d;
            m_q     <= m_d;
            r_q     <= r_d;
            g_q     <= g_d;
            h_out_q <= h_out_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign h_out_o = h_out_q;

endmodule

// File: tb/tb_blake512_compress_ctrl.sv
// Directed bench for blake512_compress_ctrl: known answer, input isolation,
// ignored start while busy, back-to-back blocks and mid-block abort.
module tb_blake512_compress_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [511:0]  h_in;
    logic [255:0]  s_in;
    logic [127:0]  t_in;
    logic [1023:0] m_in;
    logic          busy, done;
    logic [511:0]  h_out;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [511:0] IV = {
        64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B, 64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
        64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B, 64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908};
    localparam logic [511:0] KAT = {
        64'h34058BE0EC49BEB3, 64'h1E5FA0B48BD081B6, 64'hB83BE13D4B9C0609, 64'hFF9102B9F69E2BBD,
        64'h054D52BC29D31BE4, 64'hFABD09B61AE50932, 64'hBA6D2478045DE6D1, 64'h97961587F6D970FA};
    localparam logic [1023:0] M_KAT = {64'd8, 64'd0, 64'd1, 768'd0, 64'h0080000000000000};
    localparam logic [127:0]  T_KAT = {64'd0, 64'd8};

    localparam logic [63:0] CST [16] = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69};

    localparam int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}};

    localparam int GSEL [8][4] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}};

    blake512_compress_ctrl #(.ROUNDS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .h_in_i  (h_in),
        .s_in_i  (s_in),
        .t_in_i  (t_in),
        .m_in_i  (m_in),
        .busy_o  (busy),
        .done_o  (done),
        .h_out_o (h_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference compression written straight from the algorithm description.
    function automatic logic [511:0] blake_ref(input logic [511:0] h, input logic [255:0] s,
                                               input logic [127:0] t, input logic [1023:0] m);
        logic [63:0]  v [16];
        logic [63:0]  mw [16];
        logic [63:0]  a, b, c, d;
        logic [511:0] res;
        int           sr;
        for (int i = 0; i < 16; i++) mw[i] = m[64*i +: 64];
        for (int i = 0; i < 8; i++)  v[i] = h[64*i +: 64];
        for (int i = 0; i < 4; i++)  v[8+i] = s[64*i +: 64] ^ CST[i];
        v[12] = t[63:0]   ^ CST[4];
        v[13] = t[63:0]   ^ CST[5];
        v[14] = t[127:64] ^ CST[6];
        v[15] = t[127:64] ^ CST[7];
        for (int r = 0; r < 16; r++) begin
            sr = r % 10;
            for (int g = 0; g < 8; g++) begin
                a = v[GSEL[g][0]]; b = v[GSEL[g][1]]; c = v[GSEL[g][2]]; d = v[GSEL[g][3]];
                a = a + b + (mw[SIG[sr][2*g]] ^ CST[SIG[sr][2*g+1]]);
                d = ror(d ^ a, 32); c = c + d; b = ror(b ^ c, 25);
                a = a + b + (mw[SIG[sr][2*g+1]] ^ CST[SIG[sr][2*g]]);
                d = ror(d ^ a, 16); c = c + d; b = ror(b ^ c, 11);
                v[GSEL[g][0]] = a; v[GSEL[g][1]] = b; v[GSEL[g][2]] = c; v[GSEL[g][3]] = d;
            end
        end
        for (int i = 0; i < 8; i++)
            res[64*i +: 64] = h[64*i +: 64] ^ s[64*(i%4) +: 64] ^ v[i] ^ v[i+8];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit with_salt);
        for (int k = 0; k < 16; k++) h_in[32*k +: 32] = $urandom;
        for (int k = 0; k < 4; k++)  t_in[32*k +: 32] = $urandom;
        for (int k = 0; k < 32; k++) m_in[32*k +: 32] = $urandom;
        if (with_salt)
            for (int k = 0; k < 8; k++) s_in[32*k +: 32] = $urandom;
    endtask

    task automatic load_kat();
        h_in = IV;
        s_in = '0;
        t_in = T_KAT;
        m_in = M_KAT;
    endtask

    // Called just after the start-sampling edge; returns cycles until done is seen.
    task automatic wait_done(input bit scramble, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = busy;
        while (!done && lat < 300) begin
            if (scramble) rand_inputs(1'b0);
            tick();
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    int lat, lat2, dones;
    bit busy_ok;
    logic [511:0] exp_first, exp_second;

    initial begin
        // Reset with activity on the inputs.
        rand_inputs(1'b1);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            rand_inputs(1'b1);
            tick();
            chk("reset_busy",  512'(busy),  512'(0));
            chk("reset_done",  512'(done),  512'(0));
            chk("reset_h_out", h_out,       512'(0));
        end
        start = 1'b0;
        load_kat();
        tick();
        rst_n = 1'b1;
        tick();

        // Known answer.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, lat, busy_ok);
        chk("kat_latency",   512'(lat),     512'(129));
        chk("kat_busy_high", 512'(busy_ok), 512'(1));
        chk("kat_busy_done", 512'(busy),    512'(0));
        chk("kat_h_out",     h_out,         KAT);
        tick();
        chk("kat_done_pulse", 512'(done), 512'(0));
        chk("kat_h_out_held", h_out,      KAT);

        // Inputs scrambled every cycle after the load edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b1, lat, busy_ok);
        chk("iso_latency", 512'(lat), 512'(129));
        chk("iso_h_out",   h_out,     KAT);
        load_kat();
        tick();

        // start pulsed mid-block is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        chk("ign_busy_at_pulse", 512'(busy), 512'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, lat, busy_ok);
        chk("ign_latency", 512'(50 + lat), 512'(129));
        chk("ign_h_out",   h_out,          KAT);
        dones = 0;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (done) dones++;
        end
        chk("ign_extra_done", 512'(dones), 512'(0));
        chk("ign_idle",       512'(busy),  512'(0));

        // Back-to-back: start held, second block chains from the first result.
        exp_first  = blake_ref(IV,  256'(0), T_KAT, M_KAT);
        exp_second = blake_ref(KAT, 256'(0), T_KAT, M_KAT);
        load_kat();
        start = 1'b1;
        tick();
        wait_done(1'b0, lat, busy_ok);
        chk("b2b_first_latency", 512'(lat), 512'(129));
        chk("b2b_first_h_out",   h_out,     exp_first);
        h_in = KAT;
        tick();
        chk("b2b_accept_busy", 512'(busy), 512'(1));
        chk("b2b_accept_done", 512'(done), 512'(0));
        start = 1'b0;
        wait_done(1'b0, lat2, busy_ok);
        chk("b2b_second_latency", 512'(lat2), 512'(129));
        chk("b2b_second_h_out",   h_out,      exp_second);
        tick();

        // Abort mid-block, then restart.
        load_kat();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (70) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  512'(busy), 512'(0));
        chk("abort_done",  512'(done), 512'(0));
        chk("abort_h_out", h_out,      512'(0));
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        rst_n = 1'b1;
        tick();
        if (done) dones++;
        chk("abort_no_done", 512'(dones), 512'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, lat, busy_ok);
        chk("restart_latency", 512'(lat), 512'(129));
        chk("restart_h_out",   h_out,     KAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
